// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core LIMP arbiter: arbitration mode and FSM state.
package letc_core_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } limp_state_e;

  function automatic arb_mode_e arb_mode(input int rr_en);
    return (rr_en != 0) ? ARB_RR : ARB_FIXED;
  endfunction

endpackage

// File: rtl/letc_core_rr_pick.sv
// Combinational priority pick starting at i_ptr and wrapping NUM_CH-1 -> 0.
// With i_ptr held at 0 it degenerates to lowest-index-wins fixed priority.
module letc_core_rr_pick #(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic                      o_valid,
  output logic [$clog2(NUM_CH)-1:0] o_idx
);

  localparam int IW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] rot;
  logic [IW:0]       sum;

  always_comb begin
    // bit i of rot is the request of channel (i_ptr + i) mod NUM_CH
    rot     = NUM_CH'({i_req, i_req} >> i_ptr);
    o_valid = 1'b0;
    o_idx   = '0;
    sum     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!o_valid && rot[i]) begin
        o_valid = 1'b1;
        sum     = {1'b0, i_ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NUM_CH)) sum = sum - (IW+1)'(NUM_CH);
        o_idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/letc_core_limp_arb.sv
// N-to-1 LIMP arbiter (round-robin or fixed priority) with grant locked until completion.
// Optional watchdog enabled by defining LETC_CORE_LIMP_ARB_WATCHDOG_EN.
module letc_core_limp_arb #(
  parameter int NUM_CH      = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CH-1:0]         i_req_valid,
  output logic [NUM_CH-1:0]         o_req_ready,
  input  logic [NUM_CH-1:0]         i_req_wen,
  input  logic [NUM_CH*2-1:0]       i_req_size,
  input  logic [NUM_CH*AW-1:0]      i_req_addr,
  input  logic [NUM_CH*DW-1:0]      i_req_wdata,
  output logic [NUM_CH*DW-1:0]      o_req_rdata,
  output logic                      o_limp_valid,
  input  logic                      i_limp_ready,
  output logic                      o_limp_wen,
  output logic [1:0]                o_limp_size,
  output logic [AW-1:0]             o_limp_addr,
  output logic [DW-1:0]             o_limp_wdata,
  input  logic [DW-1:0]             i_limp_rdata,
  output logic [$clog2(NUM_CH)-1:0] o_grant_idx,
  output logic                      o_timeout,
  output logic                      o_dbg_state
);
  import letc_core_pkg::*;

  localparam int        IW   = $clog2(NUM_CH);
  localparam arb_mode_e MODE = arb_mode(RR_EN);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("letc_core_limp_arb: NUM_CH must be 2..8 and TIMEOUT_CYC >= 1");
  end

  // Handshake: a requester raises i_req_valid and holds it with stable fields
  // until its o_req_ready pulse; o_limp_valid stays high until i_limp_ready
  // completes the transfer in that same cycle.
  limp_state_e   state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick_ptr, pick_idx;
  logic          pick_valid;
  logic          done;
  logic          busy;

  assign pick_ptr = (MODE == ARB_RR) ? ptr_q : '0;

  letc_core_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (pick_ptr),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_limp_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          if (MODE == ARB_RR) begin
            ptr_d = (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q == ST_BUSY);

  always_comb begin
    o_limp_valid = busy;
    o_limp_wen   = 1'b0;
    o_limp_size  = '0;
    o_limp_addr  = '0;
    o_limp_wdata = '0;
    o_req_ready  = '0;
    o_req_rdata  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == IW'(c)) begin
        if (busy) begin
          o_limp_wen   = i_req_wen[c];
          o_limp_size  = i_req_size[c*2 +: 2];
          o_limp_addr  = i_req_addr[c*AW +: AW];
          o_limp_wdata = i_req_wdata[c*DW +: DW];
        end
        o_req_ready[c] = done;
        if (done) o_req_rdata[c*DW +: DW] = i_limp_rdata;
      end
    end
  end

  assign o_grant_idx = grant_q;
  assign o_dbg_state = state_q;

`ifdef LETC_CORE_LIMP_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;

  // Counter saturates at the limit so a very long stall cannot wrap it.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == ST_IDLE) begin
      if (pick_valid) wd_cnt_d = '0;
    end else if (wd_cnt_q != CW'(TIMEOUT_CYC)) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
    if (busy && wd_cnt_d == CW'(TIMEOUT_CYC)) timeout_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
  a_hold_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    busy |-> i_req_valid[grant_q]);
`endif

endmodule

// File: tb/tb_letc_core_limp_arb.sv
// Bench for letc_core_limp_arb: vector table, directed corner sequences and a
// scoreboarded random traffic phase (round-robin and fixed-priority instances).
module tb_letc_core_limp_arb;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef LETC_CORE_LIMP_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // round-robin instance
  logic [N-1:0]    req_valid, req_ready, req_wen;
  logic [N*2-1:0]  req_size;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, req_rdata;
  logic            limp_valid, limp_ready, limp_wen;
  logic [1:0]      limp_size;
  logic [AW-1:0]   limp_addr;
  logic [DW-1:0]   limp_wdata, limp_rdata;
  logic [1:0]      grant_idx;
  logic            timeout, dbg_state;

  // fixed-priority instance
  logic [N-1:0]    req_valid_f, req_ready_f;
  logic [N*DW-1:0] req_rdata_f;
  logic            limp_valid_f, limp_ready_f, limp_wen_f;
  logic [1:0]      limp_size_f;
  logic [AW-1:0]   limp_addr_f;
  logic [DW-1:0]   limp_wdata_f;
  logic [1:0]      grant_idx_f;
  logic            timeout_f, dbg_state_f;

  letc_core_limp_arb #(.NUM_CH(N), .AW(AW), .DW(DW), .RR_EN(1), .TIMEOUT_CYC(TO)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_rdata(req_rdata), .o_limp_valid(limp_valid), .i_limp_ready(limp_ready),
    .o_limp_wen(limp_wen), .o_limp_size(limp_size), .o_limp_addr(limp_addr),
    .o_limp_wdata(limp_wdata), .i_limp_rdata(limp_rdata), .o_grant_idx(grant_idx),
    .o_timeout(timeout), .o_dbg_state(dbg_state)
  );

  letc_core_limp_arb #(.NUM_CH(N), .AW(AW), .DW(DW), .RR_EN(0), .TIMEOUT_CYC(TO)) u_dut_fixed (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid_f), .o_req_ready(req_ready_f), .i_req_wen(req_wen),
    .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_rdata(req_rdata_f), .o_limp_valid(limp_valid_f), .i_limp_ready(limp_ready_f),
    .o_limp_wen(limp_wen_f), .o_limp_size(limp_size_f), .o_limp_addr(limp_addr_f),
    .o_limp_wdata(limp_wdata_f), .i_limp_rdata(limp_rdata), .o_grant_idx(grant_idx_f),
    .o_timeout(timeout_f), .o_dbg_state(dbg_state_f)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [AW-1:0] ch_addr [N];
  logic [N-1:0]  ch_wen;
  logic [1:0]    ch_size [N];

  // scoreboard: {channel, address} of each granted transaction
  logic [AW+1:0] exp_q [$];
  int            m_state, m_grant, m_ptr;
  logic [N-1:0]  pend;

  typedef struct {
    logic [N-1:0]  valid;
    logic          ready;
    logic [DW-1:0] rdata;
    logic [1:0]    g;
    logic [N-1:0]  rdy;
    logic          lv;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic clear_inputs();
    req_valid    = '0;
    req_valid_f  = '0;
    limp_ready   = 1'b0;
    limp_ready_f = 1'b0;
    limp_rdata   = '0;
    for (int c = 0; c < N; c++) begin
      req_addr[c*AW +: AW]  = ch_addr[c];
      req_wdata[c*DW +: DW] = 32'h5A00_0000 + 32'(c);
      req_size[c*2 +: 2]    = ch_size[c];
    end
    req_wen = ch_wen;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic sb_cycle(input bit allow_new);
    int            win;
    logic [N-1:0]  exp_rdy;
    logic [AW+1:0] e;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (!pend[c]) begin
        req_valid[c] = 1'b0;
        if (allow_new && $urandom_range(0, 1) == 1) begin
          pend[c] = 1'b1;
          req_valid[c] = 1'b1;
          req_addr[c*AW +: AW] = $urandom;
          req_wen[c] = 1'($urandom_range(0, 1));
        end
      end
    end
    if (m_state == 1) limp_ready = allow_new ? ($urandom_range(0, 2) == 0) : 1'b1;
    else              limp_ready = 1'($urandom_range(0, 1));
    limp_rdata = $urandom;
    #1;
    win = 0;
    if (m_state == 0 && req_valid != 0) begin
      win = model_pick(req_valid, m_ptr);
      exp_q.push_back({2'(win), req_addr[win*AW +: AW]});
    end
    exp_rdy = (m_state == 1 && limp_ready) ? N'(1 << m_grant) : '0;
    chk("sb_ready", 64'(req_ready), 64'(exp_rdy));
    if (m_state == 1 && limp_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_queue_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", 64'(grant_idx), 64'(e[AW+1:AW]));
        chk("sb_addr", 64'(limp_addr), 64'(e[AW-1:0]));
        chk("sb_rdata", 64'(req_rdata[m_grant*DW +: DW]), 64'(limp_rdata));
      end
    end
    if (m_state == 0 && req_valid != 0) begin
      m_state = 1;
      m_grant = win;
    end else if (m_state == 1 && limp_ready) begin
      m_state = 0;
      m_ptr = (m_grant + 1) % N;
      pend[m_grant] = 1'b0;
    end
  endtask

  initial begin
    ch_addr[0] = 32'h1000_0000;
    ch_addr[1] = 32'h2000_0010;
    ch_addr[2] = 32'h3000_0020;
    ch_size[0] = 2'd0;
    ch_size[1] = 2'd1;
    ch_size[2] = 2'd2;
    ch_wen     = 3'b101;

    // valid, ready, rdata, exp grant, exp o_req_ready, exp o_limp_valid
    vt[0]  = '{3'b000, 1'b1, 32'hA000_0000, 2'd0, 3'b000, 1'b0};
    vt[1]  = '{3'b000, 1'b1, 32'hA000_0001, 2'd0, 3'b000, 1'b0};
    vt[2]  = '{3'b111, 1'b1, 32'hA000_0002, 2'd0, 3'b000, 1'b0};
    vt[3]  = '{3'b111, 1'b1, 32'hA000_0003, 2'd0, 3'b001, 1'b1};
    vt[4]  = '{3'b111, 1'b1, 32'hA000_0004, 2'd0, 3'b000, 1'b0};
    vt[5]  = '{3'b111, 1'b1, 32'hA000_0005, 2'd1, 3'b010, 1'b1};
    vt[6]  = '{3'b111, 1'b1, 32'hA000_0006, 2'd1, 3'b000, 1'b0};
    vt[7]  = '{3'b111, 1'b1, 32'hA000_0007, 2'd2, 3'b100, 1'b1};
    vt[8]  = '{3'b111, 1'b1, 32'hA000_0008, 2'd2, 3'b000, 1'b0};
    vt[9]  = '{3'b111, 1'b1, 32'hA000_0009, 2'd0, 3'b001, 1'b1};
    vt[10] = '{3'b111, 1'b1, 32'hA000_000A, 2'd0, 3'b000, 1'b0};
    vt[11] = '{3'b111, 1'b1, 32'hA000_000B, 2'd1, 3'b010, 1'b1};
    vt[12] = '{3'b111, 1'b1, 32'hA000_000C, 2'd1, 3'b000, 1'b0};
    vt[13] = '{3'b111, 1'b1, 32'hA000_000D, 2'd2, 3'b100, 1'b1};

    rst = 1'b1;
    clear_inputs();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_limp_valid", 64'(limp_valid), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_addr", 64'(limp_addr), 64'd0);
    chk("rst_rdata_any", 64'(|req_rdata), 64'd0);
    reset_dut();

    // round-robin sequence, all channels valid, 1-cycle downstream ready
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req_valid  = vt[i].valid;
      limp_ready = vt[i].ready;
      limp_rdata = vt[i].rdata;
      #1;
      chk($sformatf("vec%0d_grant", i), 64'(grant_idx), 64'(vt[i].g));
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vt[i].rdy));
      chk($sformatf("vec%0d_limp_valid", i), 64'(limp_valid), 64'(vt[i].lv));
      chk($sformatf("vec%0d_addr", i), 64'(limp_addr), vt[i].lv ? 64'(ch_addr[vt[i].g]) : 64'd0);
      chk($sformatf("vec%0d_wen", i), 64'(limp_wen), vt[i].lv ? 64'(ch_wen[vt[i].g]) : 64'd0);
      chk($sformatf("vec%0d_size", i), 64'(limp_size), vt[i].lv ? 64'(ch_size[vt[i].g]) : 64'd0);
      for (int c = 0; c < N; c++) begin
        chk($sformatf("vec%0d_rdata%0d", i, c), 64'(req_rdata[c*DW +: DW]),
            vt[i].rdy[c] ? 64'(vt[i].rdata) : 64'd0);
      end
    end

    // grant locked while BUSY; late requester on ch2 wins next
    reset_dut();
    @(negedge clk);
    req_valid = 3'b001;
    #1 chk("lock_idle", 64'(dbg_state), 64'd0);
    @(negedge clk);
    req_valid[2] = 1'b1;
    #1 chk("lock_busy", 64'(dbg_state), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lock_grant%0d", k), 64'(grant_idx), 64'd0);
      chk($sformatf("lock_noready%0d", k), 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    limp_ready = 1'b1;
    #1 chk("lock_done", 64'(req_ready), 64'b001);
    @(negedge clk);
    limp_ready = 1'b0;
    req_valid[0] = 1'b0;
    #1 chk("lock_back_idle", 64'(dbg_state), 64'd0);
    @(negedge clk);
    #1;
    chk("lock_next_grant", 64'(grant_idx), 64'd2);
    chk("lock_next_addr", 64'(limp_addr), 64'(ch_addr[2]));
    @(negedge clk);
    limp_ready = 1'b1;
    #1 chk("lock_next_done", 64'(req_ready), 64'b100);

    // read on ch1 returns DEADBEEF only on ch1
    reset_dut();
    @(negedge clk);
    req_valid = 3'b010;
    @(negedge clk);
    limp_ready = 1'b1;
    limp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_rdata1", 64'(req_rdata[1*DW +: DW]), 64'hDEAD_BEEF);
    chk("rd_rdata0", 64'(req_rdata[0*DW +: DW]), 64'd0);
    chk("rd_rdata2", 64'(req_rdata[2*DW +: DW]), 64'd0);
    chk("rd_wen", 64'(limp_wen), 64'd0);

    // reset pulse in BUSY aborts with no strobe
    reset_dut();
    @(negedge clk);
    req_valid = 3'b100;
    @(negedge clk);
    #1 chk("abort_pre_grant", 64'(grant_idx), 64'd2);
    @(negedge clk);
    limp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd0);
    chk("abort_limp_valid", 64'(limp_valid), 64'd0);
    chk("abort_grant", 64'(grant_idx), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    chk("abort_rdata_any", 64'(|req_rdata), 64'd0);
    chk("abort_addr", 64'(limp_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    limp_ready = 1'b0;
    @(negedge clk);
    #1 chk("abort_reissue_grant", 64'(grant_idx), 64'd2);
    @(negedge clk);
    limp_ready = 1'b1;
    #1 chk("abort_reissue_done", 64'(req_ready), 64'b100);

    // fixed priority: ch1 always wins over ch2
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid_f  = 3'b110;
      limp_ready_f = 1'b1;
      #1;
      chk($sformatf("fixed_ready%0d", k), 64'(req_ready_f), (k % 2 == 1) ? 64'b010 : 64'd0);
      chk($sformatf("fixed_grant%0d", k), 64'(grant_idx_f), (k == 0) ? 64'd0 : 64'd1);
      chk($sformatf("fixed_lv%0d", k), 64'(limp_valid_f), 64'(k % 2));
    end

    // watchdog: ready withheld for 10 BUSY cycles
    reset_dut();
    @(negedge clk);
    req_valid = 3'b001;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      #1 chk($sformatf("wd_busy%0d", m), 64'(timeout), 64'(WD_EN && m >= 9));
    end
    @(negedge clk);
    limp_ready = 1'b1;
    #1 chk("wd_done", 64'(req_ready), 64'b001);
    @(negedge clk);
    limp_ready = 1'b0;
    req_valid = '0;
    #1 chk("wd_sticky", 64'(timeout), 64'(WD_EN));
    rst = 1'b1;
    #1 chk("wd_cleared", 64'(timeout), 64'd0);
    rst = 1'b0;

    // scoreboarded random traffic
    reset_dut();
    m_state = 0;
    m_grant = 0;
    m_ptr   = 0;
    pend    = '0;
    for (int k = 0; k < 200; k++) sb_cycle(1'b1);
    for (int k = 0; k < 20; k++) sb_cycle(1'b0);
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/letc_core_limp_arb.md
LETC_CORE_LIMP_ARB -- requirements
Module: letc_core_limp_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of LIMP requester channels (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter RR_EN, default 1: 1 selects round-robin; 0 selects fixed priority, with the lowest index winning.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: watchdog limit in cycles.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
- i_clk  in  1  clock
- i_rst  in  1  async active-high reset
- i_req_valid  in  NUM_CH  per-channel request valid
- o_req_ready  out  NUM_CH  per-channel completion strobe
- i_req_wen  in  NUM_CH  1=write, 0=read
- i_req_size  in  NUM_CH*2  access size
- i_req_addr  in  NUM_CH*AW  request address
- i_req_wdata  in  NUM_CH*DW  write data
- o_req_rdata  out  NUM_CH*DW  read data, valid with ready
- o_limp_valid  out  1  downstream request valid
- i_limp_ready  in  1  downstream completion
- o_limp_wen / o_limp_size / o_limp_addr / o_limp_wdata  out  1/2/AW/DW  forwarded request
- i_limp_rdata  in  DW  downstream read data
- o_grant_idx  out  $clog2(NUM_CH)  current owner
- o_timeout  out  1  sticky watchdog flag

Function
REQ-007 SHALL implement a two-state FSM:
- IDLE: when any i_req_valid is high, latch the winner into the grant register and go to BUSY on the next edge.
- Arbitration adds one cycle of latency.
REQ-008 In BUSY:
- o_limp_valid SHALL be 1.
- Downstream fields SHALL be muxed combinationally from the granted channel.
REQ-009 On i_limp_ready in BUSY:
- The granted channel's o_req_ready SHALL be 1 for exactly that cycle.
- Its o_req_rdata SHALL equal i_limp_rdata in that cycle.
- The FSM SHALL return to IDLE.
REQ-010 o_req_ready SHALL never be asserted for a non-granted channel, or in IDLE.
- o_req_rdata of non-ready channels SHALL be 0.
REQ-011 The grant SHALL be locked until completion; a new request arriving mid-transaction SHALL NOT preempt it.
REQ-012 Round-robin (RR_EN=1):
- On completion the pointer SHALL become (grant+1) mod NUM_CH.
- Search SHALL start at the pointer and wrap from NUM_CH-1 to 0.
REQ-013 Fixed priority (RR_EN=0): the pointer SHALL be ignored.
REQ-014 If i_limp_ready is seen in IDLE, it SHALL be ignored and no o_req_ready SHALL be produced.
REQ-015 Back-to-back operation:
- A channel SHALL be grantable again in the cycle after IDLE is re-entered.
- Maximum throughput is one transaction per 2 cycles plus the downstream latency.
REQ-016 A requester that drops i_req_valid while granted is a protocol violation; an assertion SHALL flag it in simulation.

Reset
REQ-017 On i_rst the block SHALL be in IDLE with:
- pointer = 0, grant = 0, o_timeout = 0
- all outputs 0
REQ-018 Reset asserted mid-transaction SHALL abort it immediately with no ready strobe; the requester re-issues after reset.

Configuration
REQ-019 With LETC_CORE_LIMP_ARB_WATCHDOG_EN defined:
- A counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- When it reaches TIMEOUT_CYC, o_timeout SHALL set and stay set until reset.
- The transaction SHALL continue normally.
REQ-020 Without LETC_CORE_LIMP_ARB_WATCHDOG_EN: the counter SHALL be absent and o_timeout SHALL be tied to 0.

Structure
REQ-021 The arbitration mode enum SHALL live in letc_core_pkg.
REQ-022 The FSM state enum SHALL live in letc_core_pkg.
REQ-023 One sub-module, letc_core_rr_pick, SHALL hold the combinational pointer-rotated priority pick.
- It is parametrised by NUM_CH.
- It is reused for fixed priority with the pointer held at 0.

Verification
REQ-024 Scenario: NUM_CH=3, RR_EN=1, all channels continuously valid, 1-cycle downstream ready -> grants are 0,1,2,0,1,2 and each o_req_ready is a single-cycle pulse.
REQ-025 Scenario: RR_EN=0, channels 1 and 2 valid -> channel 1 is always granted and channel 2 is starved.
REQ-026 Scenario: channel 0 is granted and channel 2 raises valid in BUSY -> o_grant_idx stays 0 until i_limp_ready; the next grant is 2.
REQ-027 Scenario: read on channel 1 with i_limp_rdata=0xDEADBEEF -> o_req_rdata[1]=0xDEADBEEF for that cycle; other rdata are 0.
REQ-028 Scenario: i_rst pulsed during BUSY -> next cycle is IDLE, all outputs 0, no ready strobe.
REQ-029 Scenario: watchdog enabled, TIMEOUT_CYC=8, ready withheld for 10 cycles -> o_timeout rises after 8 BUSY cycles, stays 1 after completion, and clears only on i_rst.
